// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e        receiver FSM state encoding
//   UartFullEtuDefault  default clocks per bit (100 MHz / 115200 baud)
//   half_etu()          clocks from a start-bit edge to its middle
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBrkWait
    } uart_state_e;

    localparam int unsigned UartFullEtuDefault = 868;

    function automatic int unsigned half_etu(input int unsigned full_etu);
        return full_etu / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit.
//   clk  in   sampling clock
//   rst  in   synchronous active-high reset, both flops load ResetValue
//   d_i  in   asynchronous input
//   q_o  out  synchronized output, two clock edges after d_i is first registered
module sync_2ff #(
    parameter logic ResetValue = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, UART_FULL_ETU clocks per bit.
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   din        in   raw serial line, asynchronous, idles high
//   data_out   out  last completed byte, held until the next completed frame
//   valid      out  one-cycle pulse, frame completed with a good stop bit
//   frame_err  out  one-cycle pulse, frame completed with stop bit low
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned UART_FULL_ETU = UartFullEtuDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err
);

    localparam int unsigned EtuW    = $clog2(UART_FULL_ETU);
    localparam int unsigned HalfEtu = half_etu(UART_FULL_ETU);

    localparam logic [EtuW-1:0] EtuLast     = EtuW'(UART_FULL_ETU - 1);
    localparam logic [EtuW-1:0] EtuHalfLast = EtuW'(HalfEtu - 1);
    localparam logic [EtuW-1:0] EtuOne      = EtuW'(1);

    logic rxs;

    sync_2ff #(
        .ResetValue (1'b1)
    ) u_sync_din (
        .clk (clk),
        .rst (rst),
        .d_i (din),
        .q_o (rxs)
    );

    uart_state_e     state_q, state_d;
    logic [EtuW-1:0] etu_cnt_q, etu_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        etu_cnt_d   = etu_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                etu_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rxs) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                // Re-check the line at mid start bit; a high here was a glitch.
                if (etu_cnt_q == EtuHalfLast) begin
                    etu_cnt_d = '0;
                    state_d   = rxs ? StIdle : StData;
                end else begin
                    etu_cnt_d = etu_cnt_q + EtuOne;
                end
            end

            StData: begin
                if (etu_cnt_q == EtuLast) begin
                    etu_cnt_d = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    etu_cnt_d = etu_cnt_q + EtuOne;
                end
            end

            StStop: begin
                if (etu_cnt_q == EtuLast) begin
                    etu_cnt_d  = '0;
                    data_out_d = shift_q;
                    if (rxs) begin
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBrkWait;
                    end
                end else begin
                    etu_cnt_d = etu_cnt_q + EtuOne;
                end
            end

            StBrkWait: begin
                // Hold off until the line returns high so a break is not seen as 0x00 frames.
                etu_cnt_d = '0;
                bit_cnt_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d   = StIdle;
                etu_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            etu_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            etu_cnt_q   <= etu_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at UART_FULL_ETU=16, plus one instance at the
// default bit period. A frame whose start bit is driven just after edge c is expected to
// pulse at edge c+3+HALF_ETU+9*UART_FULL_ETU (two sync edges plus the IDLE detect edge).
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       din_dflt = 1'b1;
    logic [7:0] data_out, data_out_dflt;
    logic       valid, valid_dflt;
    logic       frame_err, frame_err_dflt;

    always #5 clk = ~clk;

    uart_rx #(
        .UART_FULL_ETU (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err)
    );

    uart_rx dut_dflt (
        .clk       (clk),
        .rst       (rst),
        .din       (din_dflt),
        .data_out  (data_out_dflt),
        .valid     (valid_dflt),
        .frame_err (frame_err_dflt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log, sampled mid-cycle.
    int v_cyc[$], v_dat[$], f_cyc[$], f_dat[$], dv_cyc[$], dv_dat[$];
    int df_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(int'(data_out));
        end
        if (frame_err) begin
            f_cyc.push_back(cyc);
            f_dat.push_back(int'(data_out));
        end
        if (valid && frame_err) both_cnt++;
        if (valid_dflt) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(int'(data_out_dflt));
        end
        if (frame_err_dflt) df_cnt++;
        if (valid_dflt && frame_err_dflt) both_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        v_cyc.delete();
        v_dat.delete();
        f_cyc.delete();
        f_dat.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first and one stop bit. p100 is the bit period in
    // hundredths of a clock so the rate can be skewed by a few percent.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p100,
                              input bit on_dflt, output int start_cyc);
        logic [9:0] bits;
        int prev;
        int nb;
        bits      = {stop, b, 1'b0};
        prev      = 0;
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            if (on_dflt) din_dflt = bits[i];
            else         din      = bits[i];
            nb = ((i + 1) * p100 + 50) / 100;
            wait_clk(nb - prev);
            prev = nb;
        end
    endtask

    int c0, c1;

    initial begin
        wait_clk(3);
        check_eq("reset_data_out", {24'd0, data_out}, 32'h00);
        check_eq("reset_valid", {31'd0, valid}, 32'd0);
        check_eq("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("reset_state", {29'd0, dut.state_q}, {29'd0, StIdle});
        rst = 1'b0;
        wait_clk(5);

        // Single frame at nominal rate.
        clear_log();
        send_frame(8'h55, 1'b1, 1600, 1'b0, c0);
        wait_clk(20);
        check_eq("single_valid_count", v_cyc.size(), 1);
        check_eq("single_valid_time", qat(v_cyc, 0) - c0, 155);
        check_eq("single_data", qat(v_dat, 0), 32'h55);
        check_eq("single_ferr_count", f_cyc.size(), 0);
        check_eq("single_data_held", {24'd0, data_out}, 32'h55);

        // Back-to-back at nominal rate, then skewed by +3% and -3%.
        clear_log();
        send_frame(8'hA3, 1'b1, 1600, 1'b0, c0);
        send_frame(8'h3C, 1'b1, 1600, 1'b0, c1);
        wait_clk(20);
        check_eq("b2b_count", v_cyc.size(), 2);
        check_eq("b2b_first_time", qat(v_cyc, 0) - c0, 155);
        check_eq("b2b_spacing", qat(v_cyc, 1) - qat(v_cyc, 0), 160);
        check_eq("b2b_data0", qat(v_dat, 0), 32'hA3);
        check_eq("b2b_data1", qat(v_dat, 1), 32'h3C);
        check_eq("b2b_ferr", f_cyc.size(), 0);

        clear_log();
        send_frame(8'hA3, 1'b1, 1648, 1'b0, c0);
        send_frame(8'h3C, 1'b1, 1648, 1'b0, c1);
        wait_clk(20);
        check_eq("fast3_count", v_cyc.size(), 2);
        check_eq("fast3_data0", qat(v_dat, 0), 32'hA3);
        check_eq("fast3_data1", qat(v_dat, 1), 32'h3C);
        check_eq("fast3_ferr", f_cyc.size(), 0);

        clear_log();
        send_frame(8'hA3, 1'b1, 1552, 1'b0, c0);
        send_frame(8'h3C, 1'b1, 1552, 1'b0, c1);
        wait_clk(20);
        check_eq("slow3_count", v_cyc.size(), 2);
        check_eq("slow3_data0", qat(v_dat, 0), 32'hA3);
        check_eq("slow3_data1", qat(v_dat, 1), 32'h3C);
        check_eq("slow3_ferr", f_cyc.size(), 0);

        // Glitch: 4-clock low pulse is rejected at the mid start-bit check.
        clear_log();
        din = 1'b0;
        wait_clk(4);
        din = 1'b1;
        wait_clk(40);
        check_eq("glitch_valid", v_cyc.size(), 0);
        check_eq("glitch_ferr", f_cyc.size(), 0);
        check_eq("glitch_state", {29'd0, dut.state_q}, {29'd0, StIdle});
        send_frame(8'h81, 1'b1, 1600, 1'b0, c0);
        wait_clk(20);
        check_eq("glitch_next_count", v_cyc.size(), 1);
        check_eq("glitch_next_time", qat(v_cyc, 0) - c0, 155);
        check_eq("glitch_next_data", qat(v_dat, 0), 32'h81);

        // Framing error followed by a 20-bit break, then a good frame.
        clear_log();
        send_frame(8'hFF, 1'b0, 1600, 1'b0, c0);
        wait_clk(20 * 16);
        check_eq("brk_ferr_count", f_cyc.size(), 1);
        check_eq("brk_ferr_time", qat(f_cyc, 0) - c0, 155);
        check_eq("brk_ferr_data", qat(f_dat, 0), 32'hFF);
        check_eq("brk_valid_count", v_cyc.size(), 0);
        check_eq("brk_state", {29'd0, dut.state_q}, {29'd0, StBrkWait});
        din = 1'b1;
        wait_clk(16);
        send_frame(8'h12, 1'b1, 1600, 1'b0, c0);
        wait_clk(20);
        check_eq("brk_next_count", v_cyc.size(), 1);
        check_eq("brk_next_data", qat(v_dat, 0), 32'h12);
        check_eq("brk_ferr_total", f_cyc.size(), 1);

        // Reset asserted during data bit 3 of an all-ones frame.
        clear_log();
        din = 1'b0;
        wait_clk(16);
        din = 1'b1;
        wait_clk(3 * 16 + 8);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        check_eq("rst_mid_data_out", {24'd0, data_out}, 32'h00);
        wait_clk(200);
        check_eq("rst_mid_valid", v_cyc.size(), 0);
        check_eq("rst_mid_ferr", f_cyc.size(), 0);
        check_eq("rst_mid_data_held", {24'd0, data_out}, 32'h00);
        send_frame(8'hC6, 1'b1, 1600, 1'b0, c0);
        wait_clk(20);
        check_eq("rst_next_count", v_cyc.size(), 1);
        check_eq("rst_next_time", qat(v_cyc, 0) - c0, 155);
        check_eq("rst_next_data", qat(v_dat, 0), 32'hC6);

        // Default bit period: pulse at E0+8246.
        send_frame(8'h5A, 1'b1, 86800, 1'b1, c0);
        wait_clk(20);
        check_eq("dflt_count", dv_cyc.size(), 1);
        check_eq("dflt_time", qat(dv_cyc, 0) - c0, 8249);
        check_eq("dflt_data", qat(dv_dat, 0), 32'h5A);
        check_eq("dflt_ferr", df_cnt, 0);

        check_eq("never_both_pulses", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8 data bits, LSB first, no parity, one stop bit, at a fixed bit period of `UART_FULL_ETU` clocks. It is the receive-side counterpart of the existing UART transmitter and shares its parameter and framing. It synchronizes the raw line, validates the start bit at mid-bit, and samples each data bit and the stop bit at mid-bit. Each received byte is presented with a one-cycle `valid` pulse, or with a `frame_err` pulse when the stop bit is bad.

## Interface
- `UART_FULL_ETU`, default 868: clocks per bit, 100 MHz / 115200 baud. Legal range is ≥ 4. `HALF_ETU = UART_FULL_ETU/2` (integer divide).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  1  raw serial line, asynchronous, idle high.
- `data_out`  out  8  last received byte; holds its value until the next completed frame.
- `valid`  out  1  one-cycle pulse: frame completed with stop bit = 1.
- `frame_err`  out  1  one-cycle pulse: frame completed with stop bit = 0.

## Operation
- Input stage: `din` passes through a 2-FF synchronizer. Both FFs reset to 1. Only the synchronized line `rxs` is used downstream.
- Counters:
  - `etu_cnt` is `$clog2(UART_FULL_ETU)` bits wide, with terminal value `UART_FULL_ETU-1`.
  - `bit_cnt` is 3 bits.
  - The shift register is 8 bits, shifting right with each new bit entering at bit 7.
- States and transitions:
  - **IDLE**: `etu_cnt`=0, `bit_cnt`=0. `rxs`=0 → START.
  - **START**:
    - Count up to `etu_cnt`==`HALF_ETU-1`, then sample `rxs`.
    - `rxs`=0 → DATA with `etu_cnt`=0.
    - `rxs`=1 → IDLE (false start/glitch). No output activity.
  - **DATA**:
    - At `etu_cnt`==`UART_FULL_ETU-1`: shift `rxs` in, set `etu_cnt`=0, increment `bit_cnt`.
    - After the 8th bit (`bit_cnt`==7) → STOP.
  - **STOP**: at `etu_cnt`==`UART_FULL_ETU-1`, sample `rxs`. In both cases `data_out` is loaded from the shift register.
    - `rxs`=1: `valid`=1 for one cycle → IDLE.
    - `rxs`=0: `frame_err`=1 for one cycle → BRK_WAIT.
  - **BRK_WAIT**: remain until `rxs`=1, then → IDLE. This prevents a held-low line (break) from being decoded as repeated 0x00 frames.
  - Illegal state encoding → IDLE, counters cleared, pulses low.
- No backpressure: the consumer must capture `data_out` on `valid`. A later frame overwrites `data_out` unconditionally.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data_out`=0x00, `valid`=0, `frame_err`=0, state IDLE, counters 0, sync FFs 1.
- Reset mid-frame aborts immediately. No pulse is produced, and `data_out` is cleared to 0.
- Let E0 be the edge at which IDLE sees `rxs`=0 and enters START.
  - `din` low reaches `rxs` 2 edges after it is first registered.
  - Start sample occurs at E0+`HALF_ETU`.
  - Data bit k (k = 0..7) is sampled at E0+`HALF_ETU`+(k+1)·`UART_FULL_ETU`.
  - Stop bit is sampled at E0+`HALF_ETU`+9·`UART_FULL_ETU`.
  - `valid`/`frame_err` are registered at the stop-sample edge and `data_out` updates on that same edge; the pulse lasts exactly one clock.
  - Default parameter: pulse at E0+8246.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit arriving immediately after one stop bit is detected. Tolerated bit-rate mismatch is approximately ±4%.
- Glitch rejection: a low pulse shorter than about `HALF_ETU` clocks returns the block to IDLE from START.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, STOP, BRK_WAIT).
  - Default `UART_FULL_ETU` constant.
  - `HALF_ETU` derivation.
  - The same package is reused by the transmitter.
- One natural sub-module: `sync_2ff` (parameterized reset value, here 1), used for `din`.
- The rest is a single FSM with a datapath in one `always` block.

## Test plan
Simulate with `UART_FULL_ETU`=16 unless noted.
- **Single frame**: drive 0x55 at the nominal rate → one `valid` pulse exactly at E0+8+9·16=E0+152, `data_out`=0x55, `frame_err` stays 0.
- **Back-to-back frames**: 0xA3 then 0x3C with one stop bit and no gap → two `valid` pulses 160 clocks apart with `data_out` 0xA3 then 0x3C. Repeat with the bit period ±3% → same result.
- **Glitch**: `din` low for 4 clocks, then high → no pulses, state returns to IDLE, and a following 0x81 frame is received correctly.
- **Framing error/break**: send 0xFF with stop bit 0, then hold low for 20 bit periods → exactly one `frame_err` pulse, `data_out`=0xFF, no `valid`. Then line high for 1 bit and frame 0x12 → `valid`, `data_out`=0x12.
- **Reset mid-frame**: assert `rst` during data bit 3 → `data_out`=0, no pulses. The next 0xC6 frame is received correctly.
- **Default parameter** (868): 0x5A → `valid` at E0+8246, `data_out`=0x5A.
